// File: rtl/qenc_pkg.sv
// qenc_pkg: shared types and constants for the quadrature encoder emulator.
//   qenc_state_e : command sequencer states (IDLE, STEP, GAP, BTN)
//   qenc_line_e  : which output line a bounce burst applies to
//   DIR_RIGHT / DIR_LEFT : cmd_dir encodings
//   ab_gray()    : AB Gray code for a direction and phase index 0..3
package qenc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        GAP  = 2'd2,
        BTN  = 2'd3
    } qenc_state_e;

    typedef enum logic [1:0] {
        LINE_NONE = 2'd0,
        LINE_A    = 2'd1,
        LINE_B    = 2'd2,
        LINE_BTN  = 2'd3
    } qenc_line_e;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;

    // Phase index 0 sits in the low bits; each entry is {A, B}.
    // Right: 11 -> 01 -> 00 -> 10, left: 11 -> 10 -> 00 -> 01.
    localparam logic [7:0] AB_SEQ_RIGHT = {2'b10, 2'b00, 2'b01, 2'b11};
    localparam logic [7:0] AB_SEQ_LEFT  = {2'b01, 2'b00, 2'b10, 2'b11};

    function automatic logic [1:0] ab_gray(input logic dir, input logic [1:0] idx);
        logic [7:0] tbl;
        tbl = (dir == DIR_RIGHT) ? AB_SEQ_RIGHT : AB_SEQ_LEFT;
        return tbl[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/qenc_phase_timer.sv
// qenc_phase_timer: loadable down-counter with a one-cycle tick at zero.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val and arm the counter (wins over counting)
//   load_val  : cycles until tick, minus one
//   tick      : high for one cycle when the armed count reaches zero
// A load of N-1 on edge t makes tick visible in the cycle that ends at
// edge t+N, so whatever acts on tick registers exactly N cycles after load.
module qenc_phase_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    logic [W-1:0] cnt;
    logic         armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= load_val;
            armed <= 1'b1;
        end else if (armed) begin
            if (cnt == '0) begin
                armed <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign tick = armed && (cnt == '0);

endmodule

// File: rtl/qenc_emulator.sv
// qenc_emulator: generates PmodENC-style quadrature A/B and button waveforms
// from step commands.
//   clk, rst    : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake, accepted only in IDLE
//   cmd_dir     : 1 = right (A falls first), 0 = left (B falls first)
//   cmd_steps   : full quadrature cycles to emit
//   cmd_btn     : press the button after the steps
//   enc_a/enc_b : quadrature lines, idle high
//   enc_btn     : button line, active high
//   busy        : command in progress
//   done        : one-cycle pulse at command completion
//   pos         : signed running position, wraps modulo 2^CNT_W
// Build option QENC_BOUNCE_EN: every line edge is followed by BOUNCE_PULSES
// toggle pairs spaced BOUNCE_CYC cycles apart. Without it the lines switch
// cleanly and the BOUNCE_* parameters only take part in a sanity check.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// STEP  | emitting quadrature edges, one every CLK_DIV cycles
// GAP   | one CLK_DIV quiet period after the last edge
// BTN   | button held high for BTN_CYC cycles
module qenc_emulator
    import qenc_pkg::*;
#(
    parameter int CLK_DIV       = 1000,
    parameter int CNT_W         = 8,
    parameter int BTN_CYC       = 5000,
    parameter int BOUNCE_CYC    = 16,
    parameter int BOUNCE_PULSES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_btn,
    output logic             enc_a,
    output logic             enc_b,
    output logic             enc_btn,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pos
);

    localparam int TMR_MAX = (CLK_DIV > BTN_CYC) ? CLK_DIV : BTN_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] PHASE_LOAD = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] BTN_LOAD   = TMR_W'(BTN_CYC - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    if (CLK_DIV < 4) begin : g_chk_div
        $error("qenc_emulator: CLK_DIV must be at least 4");
    end
    if (BTN_CYC < 1 || BOUNCE_CYC < 1 || BOUNCE_PULSES < 0) begin : g_chk_params
        $error("qenc_emulator: BTN_CYC and BOUNCE_CYC must be >= 1, BOUNCE_PULSES >= 0");
    end

    qenc_state_e      state, state_n;
    logic [1:0]       ab_q, ab_n;
    logic             btn_q, btn_n;
    logic [CNT_W-1:0] pos_q, pos_n;
    logic [CNT_W-1:0] left_q, left_n;
    logic [1:0]       ph_q, ph_n;
    logic             dir_q, dir_n;
    logic             btnreq_q, btnreq_n;
    logic             done_q, done_n;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_tick;

    qenc_phase_timer #(.W(TMR_W)) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tmr_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ab_q     <= 2'b11;
            btn_q    <= 1'b0;
            pos_q    <= '0;
            left_q   <= '0;
            ph_q     <= 2'd0;
            dir_q    <= DIR_LEFT;
            btnreq_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            ab_q     <= ab_n;
            btn_q    <= btn_n;
            pos_q    <= pos_n;
            left_q   <= left_n;
            ph_q     <= ph_n;
            dir_q    <= dir_n;
            btnreq_q <= btnreq_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        ab_n     = ab_q;
        btn_n    = btn_q;
        pos_n    = pos_q;
        left_n   = left_q;
        ph_n     = ph_q;
        dir_n    = dir_q;
        btnreq_n = btnreq_q;
        done_n   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = PHASE_LOAD;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    dir_n    = cmd_dir;
                    btnreq_n = cmd_btn;
                    left_n   = cmd_steps;
                    ph_n     = 2'd0;
                    tmr_load = 1'b1;
                    state_n  = (cmd_steps != '0) ? STEP : GAP;
                end
            end
            STEP: begin
                if (tmr_tick) begin
                    ph_n     = ph_q + 2'd1;
                    ab_n     = ab_gray(dir_q, ph_q + 2'd1);
                    tmr_load = 1'b1;
                    // Phase 3 -> 0 is the return to AB = 11: one detent done.
                    if (ph_q == 2'd3) begin
                        pos_n  = (dir_q == DIR_RIGHT) ? pos_q + ONE : pos_q - ONE;
                        left_n = left_q - ONE;
                        if (left_q == ONE) begin
                            state_n = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (tmr_tick) begin
                    if (btnreq_q) begin
                        btn_n    = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = BTN_LOAD;
                        state_n  = BTN;
                    end else begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            BTN: begin
                if (tmr_tick) begin
                    btn_n   = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign pos       = pos_q;

`ifdef QENC_BOUNCE_EN
    localparam int BT_W = $clog2(BOUNCE_CYC + 1);
    localparam int BL_W = $clog2(2 * BOUNCE_PULSES + 2);
    localparam logic [BT_W-1:0] BOUNCE_LOAD = BT_W'(BOUNCE_CYC - 1);
    localparam logic [BL_W-1:0] BOUNCE_TOGGLES = BL_W'(2 * BOUNCE_PULSES);

    if (2 * BOUNCE_PULSES * BOUNCE_CYC >= CLK_DIV) begin : g_chk_bounce_div
        $error("qenc_emulator: bounce burst must fit inside one CLK_DIV phase");
    end
    if (2 * BOUNCE_PULSES * BOUNCE_CYC >= BTN_CYC) begin : g_chk_bounce_btn
        $error("qenc_emulator: bounce burst must fit inside the button press");
    end

    qenc_line_e      ev_line;
    qenc_line_e      b_line;
    logic            b_mask;
    logic [BL_W-1:0] b_left;
    logic            b_load;
    logic            b_tick;

    // At most one line changes per edge, so a single burst engine suffices.
    always_comb begin
        ev_line = LINE_NONE;
        if (ab_n[1] != ab_q[1]) begin
            ev_line = LINE_A;
        end else if (ab_n[0] != ab_q[0]) begin
            ev_line = LINE_B;
        end else if (btn_n != btn_q) begin
            ev_line = LINE_BTN;
        end
    end

    assign b_load = (ev_line != LINE_NONE) || (b_tick && (b_left > BL_W'(1)));

    qenc_phase_timer #(.W(BT_W)) u_bounce_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (b_load),
        .load_val (BOUNCE_LOAD),
        .tick     (b_tick)
    );

    // b_mask is XORed onto the clean line; an even number of toggles
    // leaves the line at its new settled value.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_line <= LINE_NONE;
            b_mask <= 1'b0;
            b_left <= '0;
        end else if (ev_line != LINE_NONE) begin
            b_line <= ev_line;
            b_mask <= 1'b0;
            b_left <= BOUNCE_TOGGLES;
        end else if (b_tick && (b_left != '0)) begin
            b_mask <= ~b_mask;
            b_left <= b_left - 1'b1;
        end
    end

    assign enc_a   = ab_q[1] ^ (b_mask && (b_line == LINE_A));
    assign enc_b   = ab_q[0] ^ (b_mask && (b_line == LINE_B));
    assign enc_btn = btn_q   ^ (b_mask && (b_line == LINE_BTN));
`else
    assign enc_a   = ab_q[1];
    assign enc_b   = ab_q[0];
    assign enc_btn = btn_q;
`endif

endmodule

// File: tb/tb_qenc_emulator.sv
module tb_qenc_emulator;
    import qenc_pkg::*;

`ifdef QENC_BOUNCE_EN
    localparam int CD   = 40;
    localparam int BTNC = 40;
    localparam int BC   = 4;
    localparam int BP   = 3;
    localparam int BWIN = 2 * BP * BC;
    localparam int TOG_EXP = 2 * BP + 1;
`else
    localparam int CD   = 4;
    localparam int BTNC = 10;
    localparam int BC   = 16;
    localparam int BP   = 3;
    localparam int BWIN = 0;
    localparam int TOG_EXP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [7:0] cmd_steps;
    logic       cmd_btn;
    logic       enc_a, enc_b, enc_btn;
    logic       busy, done;
    logic [7:0] pos;

    qenc_emulator #(
        .CLK_DIV(CD), .CNT_W(8), .BTN_CYC(BTNC),
        .BOUNCE_CYC(BC), .BOUNCE_PULSES(BP)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_btn(cmd_btn),
        .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
        .busy(busy), .done(done), .pos(pos)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: a command is described by its accept cycle and
    // arguments; every output is a closed-form function of cycles since accept.
    logic [1:0] seq_r [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
    logic [1:0] seq_l [4] = '{2'b11, 2'b10, 2'b00, 2'b01};
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    int         t0 = 0;
    bit         m_dir = 1'b0;
    bit         m_btn = 1'b0;
    int         m_steps = 0;
    logic [7:0] m_pos = 8'd0;
    logic [7:0] m_pos0 = 8'd0;

    logic       pa = 1'b1, pb = 1'b1, pbtn = 1'b0;
    int         lc_a = -100000, lc_b = -100000, lc_btn = -100000;
    logic       prev_a = 1'b1;
    int         a_tog = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int end_off();
        return (4 * m_steps + 1) * CD + (m_btn ? BTNC : 0);
    endfunction

    function automatic logic [7:0] pos_after(int k);
        logic [7:0] n;
        n = 8'(k / 4);
        return m_dir ? m_pos0 + n : m_pos0 - n;
    endfunction

    function automatic bit in_win(int lc);
        return (cyc - lc >= 1) && (cyc - lc < BWIN);
    endfunction

    task automatic cycle(input logic v, input logic d, input int s, input logic b, input logic r);
        int dd, k;
        logic [1:0] e_ab;
        logic       e_btn;
        logic [7:0] e_pos;
        cmd_valid = v;
        cmd_dir   = d;
        cmd_steps = 8'(s);
        cmd_btn   = b;
        rst       = r;
        @(posedge clk);
        cyc++;
        m_done = 1'b0;
        if (r) begin
            m_busy = 1'b0;
            m_pos  = 8'd0;
        end else if (m_busy) begin
            if (cyc - t0 == end_off()) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_pos  = pos_after(4 * m_steps);
            end
        end else if (v) begin
            m_busy  = 1'b1;
            t0      = cyc;
            m_dir   = d;
            m_steps = s;
            m_btn   = b;
            m_pos0  = m_pos;
        end
        @(negedge clk);
        if (m_busy) begin
            dd = cyc - t0;
            k  = dd / CD;
            if (k > 4 * m_steps) k = 4 * m_steps;
            e_ab  = m_dir ? seq_r[k % 4] : seq_l[k % 4];
            e_pos = pos_after(k);
            e_btn = m_btn && (dd >= (4 * m_steps + 1) * CD);
        end else begin
            e_ab  = 2'b11;
            e_pos = m_pos;
            e_btn = 1'b0;
        end
        if (e_ab[1] != pa) lc_a = cyc;
        if (e_ab[0] != pb) lc_b = cyc;
        if (e_btn != pbtn) lc_btn = cyc;
        if (r) begin
            lc_a = -100000; lc_b = -100000; lc_btn = -100000;
        end
        pa = e_ab[1]; pb = e_ab[0]; pbtn = e_btn;
        if (!in_win(lc_a))   check_val("enc_a", enc_a, e_ab[1]);
        if (!in_win(lc_b))   check_val("enc_b", enc_b, e_ab[0]);
        if (!in_win(lc_btn)) check_val("enc_btn", enc_btn, e_btn);
        check_val("pos", pos, e_pos);
        check_val("busy", busy, m_busy);
        check_val("done", done, m_done);
        check_val("cmd_ready", cmd_ready, !m_busy && !r);
        if (m_busy && cyc == t0) a_tog = 0;
        else if (enc_a !== prev_a) a_tog++;
        prev_a = enc_a;
    endtask

    task automatic idle();
        cycle(1'b0, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4000 && m_busy; i++) idle();
        check_val("idle_reached", busy, 0);
    endtask

    task automatic run_cmd(input logic d, input int s, input logic b);
        wait_idle();
        cycle(1'b1, d, s, b, 1'b0);
        wait_idle();
    endtask

    initial begin
        // Reset for 3 cycles, then release.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Right, 2 steps: pos 1 then 2, done at t0 + 9*CD.
        run_cmd(DIR_RIGHT, 2, 1'b0);
        check_val("pos_after_right2", pos, 8'd2);

        // Left from 0: wraps to 0xFF.
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 0, 1'b0, 0);
        run_cmd(DIR_LEFT, 1, 1'b0);
        check_val("pos_wrap", pos, 8'hFF);

        // Button only: no A/B edges.
        run_cmd(DIR_LEFT, 0, 1'b1);

        // Reset in the middle of a 2-step command.
        wait_idle();
        cycle(1'b1, DIR_RIGHT, 2, 1'b0, 1'b0);
        while (cyc < t0 + 2 * CD + 1) idle();
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
        check_val("ready_after_rst", cmd_ready, 1);

        // Toggles on A around its first edge of a right command.
        wait_idle();
        cycle(1'b1, DIR_RIGHT, 1, 1'b0, 1'b0);
        while (cyc - t0 < 2 * CD - 1) idle();
        check_val("a_toggles", a_tog, TOG_EXP);
        wait_idle();

        // Random traffic, including cmd_valid pulses while busy.
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 3) == 0), 1'($urandom), int'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom_range(0, 499) == 0));
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
